// File: rtl/spi_arbiter_pkg.sv
// Shared types for the SPI arbiter.
//   SlaveSelect : slave-select code driven to the SS mux (SS_NONE = nobody selected)
//   arb_state_e : arbiter FSM states
package spi_arbiter_pkg;

   typedef enum logic [2:0] {
      SS_NONE   = 3'd0,
      SS_CH1    = 3'd1,
      SS_CH2    = 3'd2,
      SS_CH3    = 3'd3,
      SS_EEPROM = 3'd4
   } SlaveSelect;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StBusy,
      StGap
   } arb_state_e;

   localparam int unsigned DefaultGapCycles     = 2;
   localparam int unsigned DefaultTimeoutCycles = 4096;

endpackage

// File: rtl/spi_arbiter_rr_pick2.sv
// Two-way round-robin pick (combinational).
//   a_req, b_req : requests
//   last_grant   : 0 = A was granted last, 1 = B was granted last
//   grant_a/b    : one-hot winner (both 0 when nobody requests)
//   any          : at least one request present
module rr_pick2 (
   input  logic a_req,
   input  logic b_req,
   input  logic last_grant,
   output logic grant_a,
   output logic grant_b,
   output logic any
);

   // On contention the requester not granted last wins.
   always_comb begin
      grant_a = a_req & (~b_req | last_grant);
      grant_b = b_req & (~a_req | ~last_grant);
      any     = a_req | b_req;
   end

endmodule

// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one SPI master between two requesters.
// Each transaction: latch winner (IDLE) -> start pulse (ISSUE) -> wait for
// SPI_done or timeout (BUSY) -> forced deselect gap (GAP).
//   clk, rst                 : clock, synchronous active-high reset
//   a_req/a_ss/a_data        : requester A (req held until a_done/a_err)
//   a_done/a_err             : A completion / timeout pulses
//   b_req/b_ss/b_data        : requester B
//   b_done/b_err             : B completion / timeout pulses
//   rd_data                  : EEP_data captured at SPI_done
//   ss, wrt_SPI, SPI_data    : to SS mux / SPI master
//   SPI_done, EEP_data       : from SPI master
//   busy                     : high in every state except IDLE
module spi_arbiter
   import spi_arbiter_pkg::*;
#(
   parameter int unsigned GAP_CYCLES     = DefaultGapCycles,
   parameter int unsigned TIMEOUT_CYCLES = DefaultTimeoutCycles
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        a_req,
   input  SlaveSelect  a_ss,
   input  logic [15:0] a_data,
   output logic        a_done,
   output logic        a_err,
   input  logic        b_req,
   input  SlaveSelect  b_ss,
   input  logic [15:0] b_data,
   output logic        b_done,
   output logic        b_err,
   output logic [7:0]  rd_data,
   output SlaveSelect  ss,
   output logic        wrt_SPI,
   output logic [15:0] SPI_data,
   input  logic        SPI_done,
   input  logic [7:0]  EEP_data,
   output logic        busy
);

   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
   localparam int unsigned GW = $clog2(GAP_CYCLES + 1);
   localparam logic [TW-1:0] TmoLast = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [GW-1:0] GapLast = GW'(GAP_CYCLES - 1);

   arb_state_e    state;
   logic          owner_b;     // 1 = current transaction belongs to B
   logic          last_grant;  // 1 = B was granted last
   SlaveSelect    own_ss;
   logic [15:0]   own_data;
   logic [TW-1:0] tmo_cnt;
   logic [GW-1:0] gap_cnt;

   logic grant_a;
   logic grant_b;
   logic any_req;

   rr_pick2 u_pick (
      .a_req      (a_req),
      .b_req      (b_req),
      .last_grant (last_grant),
      .grant_a    (grant_a),
      .grant_b    (grant_b),
      .any        (any_req)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= StIdle;
         owner_b    <= 1'b0;
         last_grant <= 1'b1;  // pretend B went last so A wins the first contention
         own_ss     <= SS_NONE;
         own_data   <= '0;
         tmo_cnt    <= '0;
         gap_cnt    <= '0;
         ss         <= SS_NONE;
         wrt_SPI    <= 1'b0;
         SPI_data   <= '0;
         rd_data    <= '0;
         a_done     <= 1'b0;
         a_err      <= 1'b0;
         b_done     <= 1'b0;
         b_err      <= 1'b0;
         busy       <= 1'b0;
      end else begin
         wrt_SPI <= 1'b0;
         a_done  <= 1'b0;
         a_err   <= 1'b0;
         b_done  <= 1'b0;
         b_err   <= 1'b0;

         unique case (state)
            StIdle: begin
               if (any_req) begin
                  // grant_a/grant_b are one-hot here, so grant_b alone names the winner.
                  owner_b    <= grant_b;
                  last_grant <= grant_b;
                  own_ss     <= grant_b ? b_ss : a_ss;
                  own_data   <= grant_b ? b_data : a_data;
                  state      <= StIssue;
                  busy       <= 1'b1;
               end
            end

            StIssue: begin
               wrt_SPI  <= 1'b1;
               ss       <= own_ss;
               SPI_data <= own_data;
               tmo_cnt  <= '0;
               state    <= StBusy;
            end

            StBusy: begin
               // SPI_done is checked first so it wins over a coincident timeout.
               if (SPI_done) begin
                  rd_data <= EEP_data;
                  a_done  <= ~owner_b;
                  b_done  <= owner_b;
                  ss      <= SS_NONE;
                  gap_cnt <= '0;
                  state   <= StGap;
               end else if (tmo_cnt == TmoLast) begin
                  a_err   <= ~owner_b;
                  b_err   <= owner_b;
                  ss      <= SS_NONE;
                  gap_cnt <= '0;
                  state   <= StGap;
               end else begin
                  tmo_cnt <= tmo_cnt + TW'(1);
               end
            end

            StGap: begin
               if (gap_cnt == GapLast) begin
                  state <= StIdle;
                  busy  <= 1'b0;
               end else begin
                  gap_cnt <= gap_cnt + GW'(1);
               end
            end

            default: begin
               state <= StIdle;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_arbiter.sv
// Self-checking bench for spi_arbiter: directed vector table, hand-written
// corner sequences (stray SPI_done, reset mid-transfer) and a randomized phase
// checked against a transaction-level model of the arbitration rules.
module tb_spi_arbiter;
   import spi_arbiter_pkg::*;

   localparam int GAP = 2;
   localparam int TO  = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        a_req, b_req;
   SlaveSelect  a_ss, b_ss;
   logic [15:0] a_data, b_data;
   logic        a_done, a_err, b_done, b_err;
   logic [7:0]  rd_data;
   SlaveSelect  ss;
   logic        wrt_SPI;
   logic [15:0] SPI_data;
   logic        SPI_done;
   logic [7:0]  EEP_data;
   logic        busy;

   int checks = 0;
   int passes = 0;

   // Model state: which requester the round-robin favours, last captured byte.
   bit         ptr_a;
   logic [7:0] rd_exp;

   spi_arbiter #(
      .GAP_CYCLES     (GAP),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .a_req    (a_req),
      .a_ss     (a_ss),
      .a_data   (a_data),
      .a_done   (a_done),
      .a_err    (a_err),
      .b_req    (b_req),
      .b_ss     (b_ss),
      .b_data   (b_data),
      .b_done   (b_done),
      .b_err    (b_err),
      .rd_data  (rd_data),
      .ss       (ss),
      .wrt_SPI  (wrt_SPI),
      .SPI_data (SPI_data),
      .SPI_done (SPI_done),
      .EEP_data (EEP_data),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      else passes++;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic bit pick_b(input bit ra, input bit rb, input bit pa);
      if (ra && rb) return !pa;
      return rb;
   endfunction

   // Slave-select discipline: never switch target to target directly, and
   // hold SS_NONE for at least GAP cycles between transactions.
   SlaveSelect prev_ss = SS_NONE;
   int         none_run = 0;
   bit         had_tgt = 0;
   always @(negedge clk) begin
      if (rst) begin
         prev_ss  = SS_NONE;
         none_run = 0;
         had_tgt  = 0;
      end else begin
         if (ss == SS_NONE) begin
            none_run++;
         end else begin
            if (prev_ss == SS_NONE && had_tgt) chk("ss_gap_len", 32'(none_run >= GAP), 1);
            if (prev_ss != SS_NONE) chk("ss_no_direct_switch", 32'(ss), 32'(prev_ss));
            had_tgt  = 1;
            none_run = 0;
         end
         prev_ss = ss;
      end
   end

   // One full transaction from request to end of gap. dly = cycles after the
   // wrt_SPI cycle before SPI_done is driven; -1 means never.
   task automatic txn(input bit own_b, input SlaveSelect ss_e, input logic [15:0] d_e,
                      input int dly, input logic [7:0] eep, input bit perturb);
      bit got;
      bit hold_ok;
      int s;
      int exp_s;
      bit exp_err;
      logic [3:0] pulses;
      got = 0;
      for (int n = 0; n < 12 && !got; n++) begin
         step();
         if (wrt_SPI) got = 1;
      end
      chk("grant_seen", 32'(got), 1);
      if (!got) return;
      chk("issue_ss", 32'(ss), 32'(ss_e));
      chk("issue_data", 32'(SPI_data), 32'(d_e));
      chk("issue_busy", 32'(busy), 1);
      if (perturb) begin
         if (own_b) begin b_data = ~b_data; b_ss = SS_CH3; end
         else begin a_data = ~a_data; a_ss = SS_CH3; end
      end
      EEP_data = eep;
      s = 0;
      hold_ok = 1;
      for (int k = 1; k <= 20 && s == 0; k++) begin
         SPI_done = (dly == k - 1);
         step();
         SPI_done = 1'b0;
         if (a_done | a_err | b_done | b_err) s = k;
         else if (ss != ss_e || SPI_data != d_e || wrt_SPI) hold_ok = 0;
      end
      exp_err = !(dly >= 0 && dly <= TO - 1);
      exp_s   = exp_err ? TO : dly + 1;
      chk("busy_hold", 32'(hold_ok), 1);
      chk("pulse_latency", 32'(s), 32'(exp_s));
      pulses = {a_done, a_err, b_done, b_err};
      chk("pulse_owner", 32'(pulses),
          32'({!own_b && !exp_err, !own_b && exp_err, own_b && !exp_err, own_b && exp_err}));
      if (!exp_err) rd_exp = eep;
      chk("rd_data", 32'(rd_data), 32'(rd_exp));
      chk("ss_released", 32'(ss), 32'(SS_NONE));
      ptr_a = own_b;
      step();
      chk("pulse_one_cycle", 32'({a_done, a_err, b_done, b_err}), 0);
      step();
      chk("gap_then_idle", 32'({busy, ss}), 32'({1'b0, SS_NONE}));
   endtask

   typedef struct {
      bit         a_lvl;
      bit         b_lvl;
      SlaveSelect as_v;
      logic [15:0] ad;
      SlaveSelect bs_v;
      logic [15:0] bd;
      int         dly;
      logic [7:0] eep;
      bit         own_b;
      bit         drop;
      bit         perturb;
   } vec_t;

   vec_t tbl[9];

   initial begin
      tbl[0] = '{1, 0, SS_CH1, 16'h1314, SS_CH2, 16'h0000, 12, 8'h11, 0, 1, 0};
      tbl[1] = '{0, 1, SS_CH1, 16'h0000, SS_EEPROM, 16'h0A00, 5, 8'h5C, 1, 1, 0};
      tbl[2] = '{1, 1, SS_CH2, 16'h2222, SS_EEPROM, 16'h0B01, 0, 8'h21, 0, 0, 0};
      tbl[3] = '{1, 1, SS_CH2, 16'h2222, SS_EEPROM, 16'h0B01, 3, 8'h32, 1, 0, 1};
      tbl[4] = '{1, 1, SS_CH2, 16'h2222, SS_EEPROM, 16'h0B01, 7, 8'h43, 0, 0, 0};
      tbl[5] = '{1, 1, SS_CH2, 16'h2222, SS_EEPROM, 16'h0B01, 15, 8'h54, 1, 1, 0};
      tbl[6] = '{1, 0, SS_CH1, 16'h0F0F, SS_CH2, 16'h0000, -1, 8'h99, 0, 1, 0};
      tbl[7] = '{0, 1, SS_CH1, 16'h0000, SS_CH3, 16'hBEEF, 15, 8'hA5, 1, 1, 1};
      tbl[8] = '{0, 1, SS_CH1, 16'h0000, SS_EEPROM, 16'h0C33, -1, 8'h77, 1, 1, 0};

      rst = 1'b1; a_req = 0; b_req = 0; a_ss = SS_NONE; b_ss = SS_NONE;
      a_data = '0; b_data = '0; SPI_done = 0; EEP_data = '0;
      ptr_a = 1; rd_exp = '0;
      step();
      step();
      chk("rst_ss", 32'(ss), 32'(SS_NONE));
      chk("rst_out", 32'({wrt_SPI, busy, a_done, a_err, b_done, b_err}), 0);
      chk("rst_data", 32'({SPI_data, rd_data}), 0);
      rst = 1'b0;
      step();

      // Directed table.
      for (int i = 0; i < 9; i++) begin
         a_req = tbl[i].a_lvl;
         b_req = tbl[i].b_lvl;
         if (tbl[i].a_lvl) begin a_ss = tbl[i].as_v; a_data = tbl[i].ad; end
         if (tbl[i].b_lvl) begin b_ss = tbl[i].bs_v; b_data = tbl[i].bd; end
         txn(tbl[i].own_b, tbl[i].own_b ? tbl[i].bs_v : tbl[i].as_v,
             tbl[i].own_b ? tbl[i].bd : tbl[i].ad, tbl[i].dly, tbl[i].eep, tbl[i].perturb);
         if (tbl[i].drop) begin
            if (tbl[i].own_b) b_req = 0; else a_req = 0;
         end
      end

      // Stray SPI_done outside BUSY: no pulse, rd_data kept.
      begin
         bit quiet;
         quiet = 1;
         EEP_data = 8'hEE;
         SPI_done = 1'b1;
         for (int k = 0; k < 4; k++) begin
            step();
            if (a_done | a_err | b_done | b_err | busy) quiet = 0;
         end
         SPI_done = 1'b0;
         step();
         chk("stray_done_quiet", 32'(quiet), 1);
         chk("stray_done_rd", 32'(rd_data), 32'(rd_exp));
      end

      // Reset in BUSY, then contention must go to A first again.
      begin
         bit got;
         a_req = 1; a_ss = SS_CH1; a_data = 16'h5555;
         got = 0;
         for (int n = 0; n < 12 && !got; n++) begin
            step();
            if (wrt_SPI) got = 1;
         end
         chk("rst_seq_grant", 32'(got), 1);
         step(); step(); step();
         rst = 1'b1;
         step();
         chk("mid_rst_ss", 32'(ss), 32'(SS_NONE));
         chk("mid_rst_out", 32'({wrt_SPI, busy, a_done, a_err, b_done, b_err}), 0);
         chk("mid_rst_rd", 32'(rd_data), 0);
         rst = 1'b0;
         ptr_a = 1; rd_exp = '0;
         b_req = 1; b_ss = SS_EEPROM; b_data = 16'h0A00;
         txn(1'b0, SS_CH1, 16'h5555, 4, 8'h3C, 1'b0);
         a_req = 0;
      end

      // Randomized phase against the model.
      for (int it = 0; it < 40; it++) begin
         bit ob;
         int d;
         if (!a_req && $urandom_range(0, 1) == 1) begin
            a_req = 1; a_ss = SlaveSelect'(3'($urandom_range(1, 4))); a_data = 16'($urandom);
         end
         if (!b_req && $urandom_range(0, 1) == 1) begin
            b_req = 1; b_ss = SlaveSelect'(3'($urandom_range(1, 4))); b_data = 16'($urandom);
         end
         if (!a_req && !b_req) begin
            a_req = 1; a_ss = SlaveSelect'(3'($urandom_range(1, 4))); a_data = 16'($urandom);
         end
         ob = pick_b(a_req, b_req, ptr_a);
         d = $urandom_range(0, 19);
         if (d > TO - 1) d = -1;
         txn(ob, ob ? b_ss : a_ss, ob ? b_data : a_data, d, 8'($urandom),
             $urandom_range(0, 3) == 0);
         if ($urandom_range(0, 3) != 0) begin
            if (ob) b_req = 0; else a_req = 0;
         end
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
